// File: rtl/tick_ctrl_pkg.sv
// Shared types and default widths for the tick controller.
package tick_ctrl_pkg;
  localparam int CNT_W_DEF   = 19;
  localparam int BURST_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_counter.sv
// Period counter: counts 0..div-1 while enabled, 'out' flags the terminal count.
module div_counter
  import tick_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  output logic             out
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_term;

  // >= keeps the counter from running away if div ever shrinks below the count.
  assign w_term = (r_cnt >= (div - CNT_W'(1)));
  assign out    = en & w_term;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_term ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tick_ctrl.sv
// Tick controller: config handshake, IDLE/RUN/DONE sequencing and tick counting.
// Handshake: a config beat transfers on a rising edge where cfg_valid && cfg_ready.
module tick_ctrl
  import tick_ctrl_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] tick_cnt,
  output state_t             dbg_state
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_div;
  logic [BURST_W-1:0] r_burst;
  logic [BURST_W-1:0] r_tick_cnt;
  logic               r_tick;
  logic               r_busy;
  logic               r_done;

  logic w_cfg_acc;
  logic w_start_acc;
  logic w_term;
  logic w_last;

  assign cfg_ready   = (r_state == IDLE);
  assign w_cfg_acc   = cfg_valid & cfg_ready;
  assign w_start_acc = start & (r_state == IDLE);
  assign w_last      = (r_burst != '0) && ((r_tick_cnt + BURST_W'(1)) == r_burst);

  div_counter #(.CNT_W(CNT_W)) u_div_counter (
    .clk (clk),
    .rst (rst),
    .clr (w_start_acc),
    .en  (r_state == RUN),
    .div (r_div),
    .out (w_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_div      <= CNT_W'(1);
      r_burst    <= '0;
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      // Config lands on the same edge as start, so a combined beat runs with the new values.
      if (w_cfg_acc) begin
        r_div   <= (cfg_div == '0) ? CNT_W'(1) : cfg_div;
        r_burst <= cfg_burst;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= RUN;
            r_busy     <= 1'b1;
            r_tick_cnt <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_term) begin
            r_tick <= 1'b1;
            if (r_tick_cnt != '1) r_tick_cnt <= r_tick_cnt + BURST_W'(1);
            if (w_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tick      = r_tick;
  assign busy      = r_busy;
  assign done      = r_done;
  assign tick_cnt  = r_tick_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tick_ctrl.sv
// Directed bench for tick_ctrl: cycle vector table plus multi-cycle sequences.
module tb_tick_ctrl;
  import tick_ctrl_pkg::*;

  localparam int CNT_W   = 19;
  localparam int BURST_W = 8;

  logic               clk;
  logic               rst;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_div;
  logic [BURST_W-1:0] cfg_burst;
  logic               start;
  logic               stop;
  logic               tick;
  logic               busy;
  logic               done;
  logic [BURST_W-1:0] tick_cnt;
  state_t             dbg_state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic               rst;
    logic               cv;
    logic [CNT_W-1:0]   div;
    logic [BURST_W-1:0] bur;
    logic               st;
    logic               sp;
    logic               e_tick;
    logic               e_busy;
    logic               e_done;
    logic               e_rdy;
    logic [BURST_W-1:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  tick_ctrl #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_burst (cfg_burst),
    .start     (start),
    .stop      (stop),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .tick_cnt  (tick_cnt),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic cv, input int dv, input int bu,
                     input logic st, input logic sp, input logic et, input logic eb,
                     input logic ed, input logic er, input int ec);
    vec_t v;
    v.rst = r; v.cv = cv; v.div = CNT_W'(dv); v.bur = BURST_W'(bu);
    v.st = st; v.sp = sp; v.e_tick = et; v.e_busy = eb; v.e_done = ed;
    v.e_rdy = er; v.e_cnt = BURST_W'(ec);
    tbl.push_back(v);
  endtask

  task automatic chk_all(input string tag, input logic et, input logic eb,
                         input logic ed, input logic er, input int ec);
    chk({tag, "_tick"}, int'(tick), int'(et));
    chk({tag, "_busy"}, int'(busy), int'(eb));
    chk({tag, "_done"}, int'(done), int'(ed));
    chk({tag, "_rdy"}, int'(cfg_ready), int'(er));
    chk({tag, "_cnt"}, int'(tick_cnt), ec);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_burst = '0;
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;

    //   rst cv div bur st sp | tick busy done rdy cnt
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0);  // reset state
    add(1, 0, 0, 0, 1, 0,   0, 0, 0, 1, 0);  // start under reset ignored
    add(0, 0, 0, 0, 1, 0,   0, 1, 0, 0, 0);  // default cfg start
    add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1);  // tick every cycle
    add(0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 2);  // start in RUN ignored
    add(0, 1, 9, 5, 0, 0,   1, 1, 0, 0, 3);  // cfg in RUN ignored
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0);  // rst mid-run
    add(0, 0, 0, 0, 1, 0,   0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1);  // div back to 1
    add(0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 1);  // stop kills due tick
    add(0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 1);  // stop in IDLE ignored
    add(0, 1, 0, 2, 0, 0,   0, 0, 0, 1, 1);  // div 0 -> 1, burst 2
    add(0, 0, 0, 0, 1, 0,   0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 2);  // enters DONE
    add(0, 1, 7, 0, 1, 1,   0, 0, 1, 1, 2);  // all ignored in DONE
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 2);
    add(0, 0, 0, 0, 1, 0,   0, 1, 0, 0, 0);  // rerun: cfg kept
    add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 2);
    add(0, 1, 4, 0, 1, 0,   0, 1, 0, 0, 0);  // cfg + start together
    add(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1);  // first tick at cycle 4
    add(0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 1);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; cfg_valid = tbl[i].cv; cfg_div = tbl[i].div;
      cfg_burst = tbl[i].bur; start = tbl[i].st; stop = tbl[i].sp;
      step();
      chk_all($sformatf("v%0d", i), tbl[i].e_tick, tbl[i].e_busy, tbl[i].e_done,
              tbl[i].e_rdy, int'(tbl[i].e_cnt));
    end
    idle_inputs();
    step();

    // Burst of 3 at div 5: ticks at 5/10/15, done at 16.
    cfg_valid = 1'b1; cfg_div = 19'd5; cfg_burst = 8'd3;
    step();
    idle_inputs();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      step();
      chk_all($sformatf("b3_c%0d", c), (c == 5 || c == 10 || c == 15), (c < 15),
              (c == 16), (c >= 16), (c >= 15) ? 3 : c / 5);
      if (c == 15) chk("b3_state_done", int'(dbg_state), int'(DONE));
    end

    // Free-run at div 3, stop as the counter hits 2.
    cfg_valid = 1'b1; cfg_div = 19'd3; cfg_burst = 8'd0;
    step();
    idle_inputs();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk($sformatf("fr_tick_c%0d", c), int'(tick), int'(c == 3 || c == 6));
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_all("fr_stop", 1'b0, 1'b0, 1'b0, 1'b1, 2);
    chk("fr_stop_state", int'(dbg_state), int'(IDLE));
    step();
    chk_all("fr_after", 1'b0, 1'b0, 1'b0, 1'b1, 2);

    // Free-run at div 1 long enough to saturate tick_cnt.
    cfg_valid = 1'b1; cfg_div = 19'd1; cfg_burst = 8'd0;
    step();
    idle_inputs();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 300; c++) step();
    chk_all("sat", 1'b1, 1'b1, 1'b0, 1'b0, 255);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_all("sat_stop", 1'b0, 1'b0, 1'b0, 1'b1, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
